// File: rtl/i2s_frame_sequencer_if.sv
// Bundle between the I2S frame sequencer and its register block / pins.
// master = register block and pin side, slave = the sequencer itself.
interface i2s_frame_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8
);
  logic              enable;
  logic [DIV_W-1:0]  cfg_div;
  logic [1:0]        cfg_wlen;
  // TX handshake: a word transfers on a pclk edge where tx_valid && tx_ready.
  // tx_data must be stable while tx_valid is high; tx_ready never depends on tx_valid.
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              sck;
  logic              ws;
  logic              sd_out;
  logic              sd_in;
  logic              busy;
  logic              underrun;
  logic [1:0]        dbg_state;

  modport master (
    output enable, cfg_div, cfg_wlen, tx_data, tx_valid, sd_in,
    input  tx_ready, rx_data, rx_valid, sck, ws, sd_out, busy, underrun, dbg_state
  );

  modport slave (
    input  enable, cfg_div, cfg_wlen, tx_data, tx_valid, sd_in,
    output tx_ready, rx_data, rx_valid, sck, ws, sd_out, busy, underrun, dbg_state
  );
endinterface

// File: rtl/i2s_frame_sequencer.sv
// Master-mode I2S engine: SCK/WS generation, TX serialiser and RX deserialiser.
// Build macro I2S_LOOPBACK_EN routes sd_out back into the RX path instead of the sd_in pin.
module i2s_frame_sequencer #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8
) (
  input logic                  pclk,
  input logic                  preset,
  i2s_frame_sequencer_if.slave bus
);
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SHIFT = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div_cnt, r_cfg_div;
  logic [1:0]        r_cfg_wlen;
  logic              r_sck, r_ws, r_sd_out;
  logic [BIT_W-1:0]  r_bit, w_wlen_m1;
  logic [BIT_W:0]    w_rx_lsh;
  logic [DATA_W-1:0] r_hold, w_load, w_rx_full, r_rx_data;
  logic              r_hold_full;
  logic [DATA_W-2:0] r_tx_sh, r_rx_sh;
  logic              r_rx_pend, r_rx_valid, r_underrun;
  logic              w_tick, w_rise, w_fall;
  logic              w_start_done, w_slot_end, w_frame_end, w_stop, w_slot_start;
  logic              w_hs, w_sd;

`ifdef I2S_LOOPBACK_EN
  assign w_sd = r_sd_out;
`else
  assign w_sd = bus.sd_in;
`endif

  always_comb begin
    case (r_cfg_wlen)
      2'd0:    w_wlen_m1 = BIT_W'(15);
      2'd1:    w_wlen_m1 = BIT_W'(23);
      default: w_wlen_m1 = BIT_W'(DATA_W - 1);
    endcase
  end

  assign w_rx_lsh     = (BIT_W + 1)'(DATA_W - 1) - {1'b0, w_wlen_m1};
  assign w_tick       = (r_state != S_IDLE) && (r_div_cnt == r_cfg_div);
  assign w_rise       = w_tick && !r_sck;
  assign w_fall       = w_tick && r_sck;
  // START runs until its second fall; r_bit counts those falls down from 1.
  assign w_start_done = w_fall && (r_state == S_START) && (r_bit == '0);
  assign w_slot_end   = w_fall && (r_state == S_SHIFT) && (r_bit == '0);
  // ws already switched back to 0 during the right slot's LSB, so ws==0 here marks frame end.
  assign w_frame_end  = w_slot_end && !r_ws;
  assign w_stop       = w_frame_end && !bus.enable;
  assign w_slot_start = w_start_done || (w_slot_end && !w_stop);
  assign w_hs         = bus.tx_valid && !r_hold_full;
  assign w_load       = r_hold_full ? r_hold : '0;
  assign w_rx_full    = {r_rx_sh, w_sd};

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.enable)  w_state_nxt = S_START;
      S_START: if (w_start_done) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_stop)       w_state_nxt = S_STOP;
      S_STOP:  if (w_fall)       w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_div_cnt  <= '0;
      r_sck      <= 1'b0;
      r_cfg_div  <= '0;
      r_cfg_wlen <= '0;
    end else if (r_state == S_IDLE) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
      if (bus.enable) begin
        r_cfg_div  <= bus.cfg_div;
        r_cfg_wlen <= bus.cfg_wlen;
      end
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_sck     <= !r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_bit      <= '0;
      r_ws       <= 1'b0;
      r_sd_out   <= 1'b0;
      r_tx_sh    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_slot_start && !r_hold_full;
      if (r_state == S_IDLE) begin
        r_bit    <= BIT_W'(1);
        r_ws     <= 1'b0;
        r_sd_out <= 1'b0;
      end else if (w_slot_start) begin
        r_bit    <= w_wlen_m1;
        r_tx_sh  <= w_load[DATA_W-2:0];
        r_sd_out <= w_load[DATA_W-1];
      end else if (w_stop) begin
        r_sd_out <= 1'b0;
      end else if (w_fall && (r_state == S_START)) begin
        r_bit <= r_bit - BIT_W'(1);
      end else if (w_fall && (r_state == S_SHIFT)) begin
        r_bit    <= r_bit - BIT_W'(1);
        r_sd_out <= r_tx_sh[DATA_W-2];
        r_tx_sh  <= {r_tx_sh[DATA_W-3:0], 1'b0};
        if (r_bit == BIT_W'(1)) r_ws <= !r_ws;
      end
    end
  end

  // A handshake coinciding with a slot-start copy wins: the copy used the old content.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_hs) begin
      r_hold      <= bus.tx_data;
      r_hold_full <= 1'b1;
    end else if (w_slot_start) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_pend  <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= r_rx_pend;
      r_rx_pend  <= w_rise && (r_state == S_SHIFT) && (r_bit == '0);
      if (w_rise && (r_state == S_SHIFT)) begin
        r_rx_sh <= w_rx_full[DATA_W-2:0];
        if (r_bit == '0) r_rx_data <= w_rx_full << w_rx_lsh;
      end
    end
  end

  assign bus.tx_ready  = !r_hold_full;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.sck       = r_sck;
  assign bus.ws        = r_ws;
  assign bus.sd_out    = r_sd_out;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.underrun  = r_underrun;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Directed bench for i2s_frame_sequencer: decodes the I2S pins independently and
// compares slot words, RX words, SCK timing and control pulses against hand-computed values.
module tb_i2s_frame_sequencer;
  localparam int DATA_W = 32;
  localparam int DIV_W  = 8;

  logic pclk = 1'b0;
  logic preset = 1'b1;

  i2s_frame_sequencer_if #(.DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

  i2s_frame_sequencer #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rx_q[$];

  bit   loop_on = 1'b0;
  bit   mon_clear = 1'b1;
  bit   mon_tx = 1'b0;
  bit   chk_period = 1'b0;
  int   exp_period = 2;
  int   dec_wlen = 16;
  int   cyc = 0;
  int   last_rise = -1;
  int   under_cnt = 0;
  int   sd_ones = 0;
  int   rx_cnt = 0;
  int   slot_cnt = 0;
  logic prev_sck = 1'b0;
  logic prev_ws = 1'b0;
  logic [31:0] dec_sh = '0;
  logic [31:0] dec_word;
  logic [31:0] exp_word;

  // External pin model: optionally wire the data line back from sd_out.
  always_comb bus.sd_in = loop_on ? bus.sd_out : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge pclk) begin
    #1;
    cyc++;
    if (mon_clear) begin
      under_cnt = 0;
      sd_ones   = 0;
      rx_cnt    = 0;
      slot_cnt  = 0;
      last_rise = -1;
      dec_sh    = '0;
      prev_ws   = 1'b0;
      prev_sck  = bus.sck;
    end else begin
      if (bus.underrun) under_cnt++;
      if (bus.sd_out) sd_ones++;
      if (bus.rx_valid) begin
        rx_cnt++;
        if (exp_rx_q.size() == 0) check("rx_unexpected", 32'(bus.rx_valid), 32'd0);
        else begin
          exp_word = exp_rx_q.pop_front();
          check("rx_data", bus.rx_data, exp_word);
        end
      end
      if (bus.sck && !prev_sck) begin
        if (chk_period && last_rise >= 0) check("sck_period", cyc - last_rise, exp_period);
        last_rise = cyc;
        dec_sh = {dec_sh[30:0], bus.sd_out};
        // I2S: the bit sampled where ws changes is the LSB of the slot just ending.
        if (mon_tx && (bus.ws != prev_ws)) begin
          slot_cnt++;
          dec_word = dec_sh << (32 - dec_wlen);
          if (exp_q.size() == 0) check("tx_unexpected", dec_word, 32'hFFFF_FFFF);
          else begin
            exp_word = exp_q.pop_front();
            check("tx_word", dec_word, exp_word);
          end
        end
        prev_ws = bus.ws;
      end
      if (!bus.sck && prev_sck && chk_period && last_rise >= 0)
        check("sck_high", cyc - last_rise, exp_period / 2);
      prev_sck = bus.sck;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_clear = 1'b1;
    @(posedge pclk);
    #2;
    mon_clear = 1'b0;
  endtask

  task automatic setup_run(input int div, input int wlen_code, input int wlen_bits, input bit loop);
    bus.cfg_div  = DIV_W'(div);
    bus.cfg_wlen = 2'(wlen_code);
    dec_wlen     = wlen_bits;
    exp_period   = 2 * (div + 1);
    chk_period   = 1'b1;
    mon_tx       = 1'b1;
    loop_on      = loop;
    clear_mon();
  endtask

  task automatic push(input logic [31:0] w);
    int i;
    i = 0;
    while (!bus.tx_ready && i < 3000) begin
      step(1);
      i++;
    end
    check("push_ready", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    step(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (bus.busy && i < budget) begin
      step(1);
      i++;
    end
    check("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_under(input int n, input int budget);
    int i;
    i = 0;
    while (under_cnt < n && i < budget) begin
      step(1);
      i++;
    end
    check("underrun_seen", 32'(under_cnt >= n), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k;
    bus.enable   = 1'b0;
    bus.cfg_div  = '0;
    bus.cfg_wlen = '0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    step(3);
    check("rst_sck", 32'(bus.sck), 32'd0);
    check("rst_ws", 32'(bus.ws), 32'd0);
    check("rst_sd_out", 32'(bus.sd_out), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_rx_data", bus.rx_data, 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_underrun", 32'(bus.underrun), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    preset = 1'b0;
    step(2);

    // Divider 3 -> 8-cycle SCK; no TX data so every slot underruns and sends zeros.
    setup_run(3, 0, 16, 1'b0);
    exp_q.push_back(32'h0);      exp_q.push_back(32'h0);
    exp_rx_q.push_back(32'h0);   exp_rx_q.push_back(32'h0);
    bus.enable = 1'b1;
    step(1);
    check("start_state", 32'(bus.dbg_state), 32'd1);
    check("busy_on", 32'(bus.busy), 32'd1);
    wait_under(1, 500);
    bus.enable = 1'b0;
    wait_idle(2000);
    step(20);
    check("ur_count", under_cnt, 32'd2);
    check("ur_slots", slot_cnt, 32'd2);
    check("ur_rx_count", rx_cnt, 32'd2);
    check("ur_sd_ones", sd_ones, 32'd0);
    check("stop_sck", 32'(bus.sck), 32'd0);
    check("stop_ws", 32'(bus.ws), 32'd0);
    check("stop_state", 32'(bus.dbg_state), 32'd0);
    check("ur_q_left", exp_q.size(), 32'd0);

    // 16-bit TX with pin loopback: left A5F0, right 0F0F.
    setup_run(1, 0, 16, 1'b1);
    exp_q.push_back(32'hA5F0_0000);    exp_q.push_back(32'h0F0F_0000);
    exp_rx_q.push_back(32'hA5F0_0000); exp_rx_q.push_back(32'h0F0F_0000);
    push(32'hA5F0_0000);
    check("tx_ready_full", 32'(bus.tx_ready), 32'd0);
    bus.enable = 1'b1;
    push(32'h0F0F_0000);
    bus.enable = 1'b0;
    wait_idle(2000);
    check("tx16_underrun", under_cnt, 32'd0);
    check("tx16_slots", slot_cnt, 32'd2);
    check("tx16_rx_count", rx_cnt, 32'd2);
    check("tx16_q_left", exp_q.size() + exp_rx_q.size(), 32'd0);

    // 24-bit slots at the fastest divider; config changes after start must be ignored.
    setup_run(0, 1, 24, 1'b1);
    exp_q.push_back(32'h1234_5600);    exp_q.push_back(32'hABCD_EF00);
    exp_rx_q.push_back(32'h1234_5600); exp_rx_q.push_back(32'hABCD_EF00);
    push(32'h1234_56FF);
    bus.enable = 1'b1;
    step(1);
    bus.cfg_div  = DIV_W'(5);
    bus.cfg_wlen = 2'd0;
    push(32'hABCD_EF01);
    bus.enable = 1'b0;
    wait_idle(2000);
    check("rx24_underrun", under_cnt, 32'd0);
    check("rx24_slots", slot_cnt, 32'd2);
    check("rx24_rx_count", rx_cnt, 32'd2);
    check("rx24_q_left", exp_q.size() + exp_rx_q.size(), 32'd0);

    // Enable dropped in the left slot and restored before the frame ends: keeps running.
    setup_run(0, 0, 16, 1'b0);
    repeat (4) begin
      exp_q.push_back(32'h0);
      exp_rx_q.push_back(32'h0);
    end
    bus.enable = 1'b1;
    wait_under(1, 300);
    bus.enable = 1'b0;
    step(3);
    bus.enable = 1'b1;
    wait_under(3, 600);
    check("reen_state", 32'(bus.dbg_state), 32'd2);
    bus.enable = 1'b0;
    wait_idle(1000);
    check("reen_underrun", under_cnt, 32'd4);
    check("reen_slots", slot_cnt, 32'd4);
    check("reen_rx_count", rx_cnt, 32'd4);

    // Reset in the middle of a 32-bit left slot: immediate reset values, no rx_valid.
    setup_run(2, 2, 32, 1'b0);
    chk_period = 1'b0;
    mon_tx = 1'b0;
    push(32'hDEAD_BEEF);
    bus.enable = 1'b1;
    k = 0;
    while (bus.dbg_state != 2'd2 && k < 500) begin
      step(1);
      k++;
    end
    check("shift_reached", 32'(bus.dbg_state), 32'd2);
    step(10);
    @(posedge pclk);
    #3;
    preset = 1'b1;
    #1;
    check("mrst_sck", 32'(bus.sck), 32'd0);
    check("mrst_ws", 32'(bus.ws), 32'd0);
    check("mrst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_sd_out", 32'(bus.sd_out), 32'd0);
    bus.enable = 1'b0;
    step(2);
    preset = 1'b0;
    step(10);
    check("mrst_rx_count", rx_cnt, 32'd0);
    check("mrst_rx_data", bus.rx_data, 32'd0);
    check("mrst_idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
